// File: rtl/store_data_gen.sv
// Store data generator: turns SB/SH/SW requests into byte-lane-aligned SRAM write beats.
// Define STORE_MISALIGN_SPLIT_EN to split word-crossing stores into two beats; otherwise they are rejected.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module store_data_gen #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [2:0]                funct3_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic [`DATA_WIDTH-1:0]    StoreData_i,
    output logic                      mem_cs_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [`DATA_WIDTH/8-1:0]  mem_we_o,
    output logic [`DATA_WIDTH-1:0]    mem_wdata_o,
    output logic                      done_o,
    output logic                      err_o
);

`ifdef STORE_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1, BEAT1 = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, BEAT0 = 2'd1} state_t;
`endif

    // Eight-lane mask spanning the addressed word and the next one.
    function automatic logic [7:0] byte_mask(input logic [2:0] size, input logic [1:0] off);
        logic [7:0] m;
        case (size)
            3'd0:    m = 8'b0000_0001;
            3'd1:    m = 8'b0000_0011;
            default: m = 8'b0000_1111;
        endcase
        return m << off;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] sd,
                                              input logic [1:0] off, input logic hi);
        logic [63:0] d;
        case (size)
            3'd0:    d = {56'd0, sd[7:0]};
            3'd1:    d = {48'd0, sd[15:0]};
            default: d = {32'd0, sd};
        endcase
        d = d << {off, 3'b000};
        return hi ? d[63:32] : d[31:0];
    endfunction

    state_t                  state_q, state_d;
    logic                    mem_cs_q, mem_cs_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]              mem_we_q, mem_we_d;
    logic [31:0]             mem_wdata_q, mem_wdata_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [7:0]              mask_s;
    logic                    split_s;
    logic                    legal_s;
    logic [ADDR_WIDTH-1:0]   base_s;
`ifdef STORE_MISALIGN_SPLIT_EN
    logic                    split_q, split_d;
    logic [ADDR_WIDTH-1:0]   hi_addr_q, hi_addr_d;
    logic [3:0]              hi_we_q, hi_we_d;
    logic [31:0]             hi_wdata_q, hi_wdata_d;
`endif

    // Request decode: lane mask, split detection and legality.
    always_comb begin
        mask_s  = byte_mask(funct3_i, addr_i[1:0]);
        split_s = |mask_s[7:4];
        base_s  = {addr_i[ADDR_WIDTH-1:2], 2'b00};
`ifdef STORE_MISALIGN_SPLIT_EN
        legal_s = (funct3_i <= 3'd2);
`else
        legal_s = (funct3_i <= 3'd2) && !split_s;
`endif
    end

    // Next state and next registered outputs; outputs default to zero outside beats.
    always_comb begin
        state_d     = state_q;
        mem_cs_d    = 1'b0;
        mem_addr_d  = '0;
        mem_we_d    = 4'b0000;
        mem_wdata_d = 32'd0;
        done_d      = 1'b0;
        err_d       = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        split_d     = split_q;
        hi_addr_d   = hi_addr_q;
        hi_we_d     = hi_we_q;
        hi_wdata_d  = hi_wdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid_i && legal_s) begin
                    state_d     = BEAT0;
                    mem_cs_d    = 1'b1;
                    mem_addr_d  = base_s;
                    mem_we_d    = mask_s[3:0];
                    mem_wdata_d = lane_data(funct3_i, StoreData_i, addr_i[1:0], 1'b0);
                    done_d      = !split_s;
`ifdef STORE_MISALIGN_SPLIT_EN
                    split_d     = split_s;
                    hi_addr_d   = base_s + {{(ADDR_WIDTH-3){1'b0}}, 3'b100};
                    hi_we_d     = mask_s[7:4];
                    hi_wdata_d  = lane_data(funct3_i, StoreData_i, addr_i[1:0], 1'b1);
`endif
                end else if (req_valid_i) begin
                    err_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            BEAT0: begin
`ifdef STORE_MISALIGN_SPLIT_EN
                if (split_q) begin
                    state_d     = BEAT1;
                    mem_cs_d    = 1'b1;
                    mem_addr_d  = hi_addr_q;
                    mem_we_d    = hi_we_q;
                    mem_wdata_d = hi_wdata_q;
                    done_d      = 1'b1;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
`ifdef STORE_MISALIGN_SPLIT_EN
            BEAT1: begin
                state_d = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            mem_cs_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_q     <= 1'b0;
            hi_addr_q   <= '0;
            hi_we_q     <= 4'b0000;
            hi_wdata_q  <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            mem_cs_q    <= mem_cs_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_q     <= split_d;
            hi_addr_q   <= hi_addr_d;
            hi_we_q     <= hi_we_d;
            hi_wdata_q  <= hi_wdata_d;
`endif
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign mem_cs_o    = mem_cs_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wdata_o = mem_wdata_q;
    assign done_o      = done_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_store_data_gen.sv
// Scoreboard bench for store_data_gen: byte-level reference model, monitor compares beats/errors by cycle.
module tb_store_data_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        mem_cs;
    logic [31:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    store_data_gen #(.ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .funct3_i(funct3), .addr_i(addr), .StoreData_i(sdata), .mem_cs_o(mem_cs),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .done_o(done), .err_o(err)
    );

    typedef struct {
        int          cyc;
        bit          is_err;
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          done;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    int   free_cyc = 0;
    bit   started = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: place each stored byte into its lane of beat 0 or beat 1.
    function automatic void model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d, input int acc);
        int n, off, p, nb;
        logic [3:0]  we [2];
        logic [31:0] wd [2];
        logic [31:0] base;
        exp_t e;
        n   = (f == 3'd0) ? 1 : (f == 3'd1) ? 2 : 4;
        off = int'(a[1:0]);
        nb  = (off + n > 4) ? 2 : 1;
        e.cyc = acc; e.is_err = 1'b0; e.addr = 32'd0; e.we = 4'd0; e.wdata = 32'd0; e.done = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
        if (f > 3'd2) begin
`else
        if (f > 3'd2 || nb == 2) begin
`endif
            e.is_err = 1'b1;
            q.push_back(e);
            free_cyc = acc;
            return;
        end
        we[0] = 4'd0; we[1] = 4'd0; wd[0] = 32'd0; wd[1] = 32'd0;
        for (int k = 0; k < n; k++) begin
            p = off + k;
            we[p/4][p%4] = 1'b1;
            wd[p/4][8*(p%4) +: 8] = d[8*k +: 8];
        end
        base = a & 32'hFFFF_FFFC;
        e.addr = base; e.we = we[0]; e.wdata = wd[0]; e.done = (nb == 1);
        q.push_back(e);
        if (nb == 2) begin
            e.cyc = acc + 1; e.addr = base + 32'd4; e.we = we[1]; e.wdata = wd[1]; e.done = 1'b1;
            q.push_back(e);
        end
        free_cyc = acc + nb;
    endfunction

    // Monitor: every output event must match the head of the scoreboard at the expected cycle.
    always @(negedge clk) begin
        if (started) begin
            if (mem_cs) begin
                tests++;
                if (q.size() == 0 || q[0].is_err) begin
                    fails++;
                    $display("FAIL unexpected_beat cyc=%0d addr=%h we=%b wdata=%h", cyc, mem_addr, mem_we, mem_wdata);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc || mem_addr !== mon_e.addr || mem_we !== mon_e.we ||
                        mem_wdata !== mon_e.wdata || done !== mon_e.done) begin
                        fails++;
                        $display("FAIL beat got cyc=%0d addr=%h we=%b wdata=%h done=%b, want cyc=%0d addr=%h we=%b wdata=%h done=%b",
                                 cyc, mem_addr, mem_we, mem_wdata, done,
                                 mon_e.cyc, mon_e.addr, mon_e.we, mon_e.wdata, mon_e.done);
                    end
                end
            end else begin
                tests++;
                if (mem_we !== 4'd0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_zero cyc=%0d addr=%h we=%b wdata=%h done=%b, want all 0",
                             cyc, mem_addr, mem_we, mem_wdata, done);
                end
            end
            if (err) begin
                tests++;
                if (q.size() == 0 || !q[0].is_err) begin
                    fails++;
                    $display("FAIL unexpected_err cyc=%0d got err=1 want 0", cyc);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.cyc != cyc) begin
                        fails++;
                        $display("FAIL err_cycle got %0d want %0d", cyc, mon_e.cyc);
                    end
                end
            end
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                tests++;
                fails++;
                mon_e = q.pop_front();
                $display("FAIL missing_event cyc=%0d got none, want is_err=%0d addr=%h", mon_e.cyc, mon_e.is_err, mon_e.addr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tests++;
        if (req_ready !== (cyc >= free_cyc)) begin
            fails++;
            $display("FAIL ready cyc=%0d got %b want %b", cyc, req_ready, (cyc >= free_cyc));
        end
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        funct3 = f; addr = a; sdata = d; req_valid = 1'b1;
        for (int w = 0; w < 10; w++) begin
            if (req_ready) begin
                model(f, a, d, cyc + 1);
                tick();
                req_valid = 1'b0;
                funct3 = 3'($urandom); addr = $urandom; sdata = $urandom;
                return;
            end
            tick();
        end
        tests++;
        fails++;
        $display("FAIL send_timeout got ready=0 want 1 within 10 cycles");
        req_valid = 1'b0;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc > cyc) q.delete(i);
        end
        free_cyc = cyc + 1;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rf;
        rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'd0; addr = 32'd0; sdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 1'b1 || mem_cs !== 1'b0 || mem_we !== 4'd0 || mem_addr !== 32'd0 ||
            mem_wdata !== 32'd0 || done !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL reset_state got ready=%b cs=%b we=%b addr=%h wdata=%h done=%b err=%b, want ready=1 rest 0",
                     req_ready, mem_cs, mem_we, mem_addr, mem_wdata, done, err);
        end
        rst_n = 1'b1;
        free_cyc = cyc;
        started = 1'b1;
        tick();

        send(3'd0, 32'h0000_0103, 32'hAABB_CCDD);
        tick();
        send(3'd1, 32'h0000_0202, 32'h0000_1234);
        send(3'd2, 32'h0000_0101, 32'h1122_3344);
        tick(); tick();
        send(3'd3, 32'h0000_0055, 32'hDEAD_BEEF);
        send(3'd1, 32'h0000_0013, 32'h0000_ABCD);
        tick(); tick();
        send(3'd2, 32'hFFFF_FFFE, 32'h5566_7788);
        reset_now();
        tick();
        send(3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D);
        tick(); tick();
        for (int i = 0; i < 6; i++) send(3'd2, 32'h0000_1000 + 32'(4 * i), $urandom);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                rf = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
                send(rf, $urandom, $urandom);
            end
        end

        repeat (5) tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
